// File: rtl/ram_array.sv
// Word-addressable RAM built from 4-bit slices, with a preset engine that
// fills every word with ones over DEPTH cycles. Define RAM_WMASK_EN for per-nibble write masking.

module ram_array_slice #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [3:0]        wdata,
  output logic [3:0]        rdata
);
  logic [DEPTH-1:0][3:0] mem;

  always_ff @(posedge clk) begin
    if (clear) begin
      mem   <= '0;
      rdata <= '0;
    end else begin
      if (wen) mem[waddr] <= wdata;
      // Same-edge write to the read address is forwarded to the output.
      rdata <= (wen && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end
endmodule

module ram_array #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic              preset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
`ifdef RAM_WMASK_EN
  input  logic [WIDTH/4-1:0] wmask,
`endif
  output logic [WIDTH-1:0]  dout,
  output logic              busy
);
  localparam int NIB = WIDTH / 4;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic [NIB-1:0]    mask;

`ifdef RAM_WMASK_EN
  assign mask = wmask;
`else
  assign mask = '1;
`endif

  assign busy = (state == FILL);

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      IDLE: if (preset) begin
        state_nx = FILL;
        ptr_nx   = '0;
      end
      FILL: begin
        // preset is deliberately not looked at here: no restart or extension.
        if (ptr == LAST) begin
          state_nx = IDLE;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  // Fill writes own the write port; user writes are dropped while busy.
  logic              fill_wr;
  logic [ADDR_W-1:0] waddr;
  assign fill_wr = busy;
  assign waddr   = fill_wr ? ptr : addr;

  for (genvar i = 0; i < NIB; i++) begin : g_slice
    logic       wen;
    logic [3:0] wdata;
    assign wen   = fill_wr | (we & mask[i]);
    assign wdata = fill_wr ? 4'hF : din[4*i +: 4];

    ram_array_slice #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_slice (
      .clk   (clk),
      .clear (clear),
      .wen   (wen),
      .waddr (waddr),
      .raddr (addr),
      .wdata (wdata),
      .rdata (dout[4*i +: 4])
    );
  end
endmodule
